debounce_bank: RTL and testbench

Parametrised multi-channel switch debouncer with edge and long-press detection for the board's push-buttons and slide switches. Each channel synchronises its raw input, applies a consecutive-sample debounce filter, and produces a stable level, single-cycle rise/fall strobes, and a hold/auto-repeat strobe. It sits between the board I/O and the control logic (mode select, parameter stepping), replacing the per-pin single-channel debouncers.

---
 rtl/debounce_bank.sv | 161 ++++++++++++++++
 tb/tb_debounce_bank.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel switch debouncer with edge and long-press detection.
//   clk       system clock
//   rst       asynchronous active-high reset
//   i_switch  raw asynchronous switch inputs, one bit per channel
//   o_state   debounced level per channel
//   o_rise    one-cycle strobe when o_state goes 0->1
//   o_fall    one-cycle strobe when o_state goes 1->0
//   o_hold    one-cycle long-press / auto-repeat strobe
// Each channel is an independent debounce_lane instance.

module debounce_lane #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int CNT_W          = 18,
  parameter int HOLD_LIMIT     = 25000000,
  parameter bit REPEAT_EN      = 1'b1,
  parameter int REPEAT_LIMIT   = 5000000,
  parameter int HOLD_W         = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic x_i,      // raw input, already polarity-corrected
  output logic state_o,
  output logic rise_o,
  output logic fall_o,
  output logic hold_o
);

  typedef enum logic [1:0] {IDLE, PRESS, REPEAT, DONE} hold_st_e;

  logic              s1_q, s2_q;
  logic              state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rise_q, rise_d, fall_q, fall_d, hold_q, hold_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  hold_st_e          fsm_q, fsm_d;

  // Debounce: a new level is accepted only after DEBOUNCE_LIMIT consecutive
  // disagreeing samples; any agreeing sample clears progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (s2_q != state_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_LIMIT - 1)) state_d = s2_q;
      else                                     cnt_d   = cnt_q + 1'b1;
    end
    rise_d = state_d & ~state_q;
    fall_d = ~state_d & state_q;
  end

  // Hold FSM works off the next-state level so the press starts counting on
  // the same edge the debounced level rises, and a release on the terminal
  // edge wins over the hold strobe.
  always_comb begin
    fsm_d  = fsm_q;
    hcnt_d = hcnt_q;
    hold_d = 1'b0;
    if (!state_d) begin
      fsm_d  = IDLE;
      hcnt_d = '0;
    end else if (rise_d) begin
      fsm_d  = PRESS;
      hcnt_d = '0;
    end else begin
      case (fsm_q)
        PRESS: begin
          if (hcnt_q == HOLD_W'(HOLD_LIMIT - 1)) begin
            hold_d = 1'b1;
            hcnt_d = '0;
            fsm_d  = REPEAT_EN ? REPEAT : DONE;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (hcnt_q == HOLD_W'(REPEAT_LIMIT - 1)) begin
            hold_d = 1'b1;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        default: hcnt_d = '0;  // IDLE / DONE: wait for release
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      hold_q  <= 1'b0;
      hcnt_q  <= '0;
      fsm_q   <= IDLE;
    end else begin
      s1_q    <= x_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      fsm_q   <= fsm_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign hold_o  = hold_q;

endmodule

module debounce_bank #(
  parameter int              N_CH           = 4,
  parameter int              DEBOUNCE_LIMIT = 250000,
  parameter int              CNT_W          = 18,
  parameter logic [N_CH-1:0] INVERT         = '0,
  parameter int              HOLD_LIMIT     = 25000000,
  parameter bit              REPEAT_EN      = 1'b1,
  parameter int              REPEAT_LIMIT   = 5000000,
  parameter int              HOLD_W         = 25
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_switch,
  output logic [N_CH-1:0] o_state,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_hold
);

  // Inversion happens ahead of the synchroniser so active-low pins read as
  // 0 out of reset and never strobe on release.
  logic [N_CH-1:0] x;
  assign x = i_switch ^ INVERT;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    debounce_lane #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
      .CNT_W         (CNT_W),
      .HOLD_LIMIT    (HOLD_LIMIT),
      .REPEAT_EN     (REPEAT_EN),
      .REPEAT_LIMIT  (REPEAT_LIMIT),
      .HOLD_W        (HOLD_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .x_i    (x[c]),
      .state_o(o_state[c]),
      .rise_o (o_rise[c]),
      .fall_o (o_fall[c]),
      .hold_o (o_hold[c])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: two instances (auto-repeat on / off) share the
// same inputs and are compared every cycle against a timing-rule model.

module tb_debounce_bank;

  localparam int         DL  = 4;
  localparam int         HL  = 10;
  localparam int         RL  = 5;
  localparam logic [1:0] INV = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sw  = 2'b10;
  logic [1:0] ost [2];
  logic [1:0] ori [2];
  logic [1:0] ofa [2];
  logic [1:0] oho [2];

  always #5 clk = ~clk;

  debounce_bank #(.N_CH(2), .DEBOUNCE_LIMIT(DL), .CNT_W(3), .INVERT(INV),
    .HOLD_LIMIT(HL), .REPEAT_EN(1'b1), .REPEAT_LIMIT(RL), .HOLD_W(4)) u_rep (
    .clk(clk), .rst(rst), .i_switch(sw),
    .o_state(ost[0]), .o_rise(ori[0]), .o_fall(ofa[0]), .o_hold(oho[0]));

  debounce_bank #(.N_CH(2), .DEBOUNCE_LIMIT(DL), .CNT_W(3), .INVERT(INV),
    .HOLD_LIMIT(HL), .REPEAT_EN(1'b0), .REPEAT_LIMIT(RL), .HOLD_W(4)) u_one (
    .clk(clk), .rst(rst), .i_switch(sw),
    .o_state(ost[1]), .o_rise(ori[1]), .o_fall(ofa[1]), .o_hold(oho[1]));

  int checks = 0;
  int errors = 0;

  // Model: sampled-input pipeline, disagreement run length, and the edge
  // number of the last rise; hold strobes follow from elapsed time.
  int   cyc;
  logic m_s1 [2], m_s2 [2], m_st [2];
  int   m_run [2];
  int   m_e [2];
  logic [1:0] m_rise, m_fall, m_hold [2];
  int   hold_cnt [2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_st[c] = 0; m_run[c] = 0; m_e[c] = 0;
    end
    m_rise = '0; m_fall = '0; m_hold[0] = '0; m_hold[1] = '0;
  endtask

  task automatic model_step();
    cyc++;
    for (int c = 0; c < 2; c++) begin
      logic old = m_st[c];
      m_run[c] = (m_s2[c] != m_st[c]) ? m_run[c] + 1 : 0;
      if (m_run[c] == DL) begin
        m_st[c]  = m_s2[c];
        m_run[c] = 0;
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = sw[c] ^ INV[c];
      m_rise[c] = m_st[c] & ~old;
      m_fall[c] = ~m_st[c] & old;
      if (m_rise[c]) m_e[c] = cyc;
      for (int d = 0; d < 2; d++) begin
        int t = cyc - m_e[c];
        m_hold[d][c] = m_st[c] && !m_rise[c] &&
          ((t == HL) || (d == 0 && t > HL && (t - HL) % RL == 0));
      end
    end
  endtask

  function automatic int elapsed0();
    return m_st[0] ? cyc - m_e[0] : -1;
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk(d == 0 ? "state_rep" : "state_one", ost[d], {m_st[1], m_st[0]});
      chk(d == 0 ? "rise_rep"  : "rise_one",  ori[d], m_rise);
      chk(d == 0 ? "fall_rep"  : "fall_one",  ofa[d], m_fall);
      chk(d == 0 ? "hold_rep"  : "hold_one",  oho[d], m_hold[d]);
      // Window of the first 40 cycles of a press on ch0.
      if (m_st[0] && (cyc - m_e[0]) >= 1 && (cyc - m_e[0]) <= 40 && oho[d][0])
        hold_cnt[d]++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    cyc = 0;
    hold_cnt[0] = 0; hold_cnt[1] = 0;
    model_reset();
    #1;
    chk("reset_state", ost[0] | ost[1], 2'b00);
    chk("reset_strobes", ori[0] | ofa[0] | oho[0] | ori[1] | ofa[1] | oho[1], 2'b00);
    steps(2);
    rst = 0;
    steps(8);  // inverted ch1 with high pin stays 0, no strobes

    // Bounce on ch0, then a long press with release.
    sw[0] = 1; step(); sw[0] = 0; step(); sw[0] = 1; step(); sw[0] = 0; step();
    sw[0] = 1;
    steps(60);
    chk("hold_pulses_rep", 2'(hold_cnt[0]), 2'(7));
    chk("hold_pulses_one", 2'(hold_cnt[1]), 2'(1));
    sw[0] = 0;
    steps(12);

    // Inverted channel press (pin driven low).
    sw[1] = 0;
    steps(15);

    // Async reset while ch0 hcnt=7 and ch1 is two samples into a release.
    sw[0] = 1;
    for (int i = 0; i < 40 && elapsed0() != 3; i++) step();
    chk("reach_t3", 2'(elapsed0() == 3), 2'b01);
    sw[1] = 1;
    for (int i = 0; i < 10 && elapsed0() != 7; i++) step();
    chk("reach_t7", 2'(elapsed0() == 7), 2'b01);
    chk("ch1_run2", 2'(m_run[1]), 2'(2));
    rst = 1;
    #1;
    model_reset();
    check_all();  // outputs cleared with no clock edge
    steps(2);
    rst = 0;
    sw = 2'b00;   // ch0 pressed? no: ch0 released, ch1 pressed (inverted)
    sw[0] = 1;
    steps(30);

    // Random phase with long and short runs and occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) sw = 2'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1;
        #1;
        model_reset();
        check_all();
        step();
        rst = 0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
